// File: rtl/checker_pkg.sv
// Shared types and helpers for the DUV/ideal lockstep checker.
// Transaction fields are sized for the widest supported bus; narrower buses are zero-extended.
package checker_pkg;

    localparam int TXN_AW = 32;
    localparam int SAT_W  = 32;

    typedef struct packed {
        logic              is_write;
        logic [TXN_AW-1:0] addr;
        logic [TXN_AW-1:0] data;
    } txn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v);
        return (v >= max_v) ? max_v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/txn_fifo.sv
// Synchronous transaction FIFO with flush; an extra pointer bit separates full from empty.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module txn_fifo
    import checker_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic flush_i,
    input  logic push_i,
    input  txn_t din_i,
    input  logic pop_i,
    output txn_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    txn_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/bus_lockstep_checker.sv
// Lockstep checker: buffers DUV and ideal memory transactions, compares them in order.
// IDLE: FIFOs flushed, waiting for enable | RUN: push, compare, time out | HALT: frozen until enable=0
module bus_lockstep_checker
    import checker_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 64,
    parameter int STOP_ON_ERR = 1,
    parameter int CNT_W       = 16
)
(
    input  logic             CLK,
    input  logic             RSTa,
    input  logic             enable,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] write_data,
    input  logic             MemRead_ideal,
    input  logic             MemWrite_ideal,
    input  logic [WIDTH-1:0] address_ideal,
    input  logic [WIDTH-1:0] write_data_ideal,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             err,
    output logic             timeout,
    output logic             overflow,
    output logic             halted,
    output logic [WIDTH-1:0] bad_addr_duv,
    output logic [WIDTH-1:0] bad_addr_ideal
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] match_q, match_d, mismatch_q, mismatch_d;
    logic             err_q, err_d, timeout_q, timeout_d, overflow_q, overflow_d;
    logic [WIDTH-1:0] bad_duv_q, bad_duv_d, bad_ideal_q, bad_ideal_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;

    txn_t txn_duv, txn_ideal, head_duv, head_ideal;
    logic run_active, push_duv, push_ideal, pop;
    logic full_duv, full_ideal, empty_duv, empty_ideal;
    logic flush, lopsided, ovf_hit, same;

    // Reads carry no data, so their data field is zeroed before buffering.
    always_comb begin
        txn_duv.is_write   = MemWrite;
        txn_duv.addr       = TXN_AW'(address);
        txn_duv.data       = MemWrite ? TXN_AW'(write_data) : '0;
        txn_ideal.is_write = MemWrite_ideal;
        txn_ideal.addr     = TXN_AW'(address_ideal);
        txn_ideal.data     = MemWrite_ideal ? TXN_AW'(write_data_ideal) : '0;
    end

    assign run_active = (state_q == RUN) && enable;
    assign push_duv   = run_active && (MemRead || MemWrite);
    assign push_ideal = run_active && (MemRead_ideal || MemWrite_ideal);
    assign pop        = run_active && !empty_duv && !empty_ideal;
    assign flush      = !enable;
    assign lopsided   = (empty_duv != empty_ideal);
    assign same       = (head_duv == head_ideal);
    assign ovf_hit    = (push_duv && full_duv && !pop) || (push_ideal && full_ideal && !pop);

    txn_fifo #(.DEPTH(DEPTH)) u_fifo_duv (
        .clk_i   (CLK),
        .rst_n_i (RSTa),
        .flush_i (flush),
        .push_i  (push_duv),
        .din_i   (txn_duv),
        .pop_i   (pop),
        .dout_o  (head_duv),
        .full_o  (full_duv),
        .empty_o (empty_duv)
    );

    txn_fifo #(.DEPTH(DEPTH)) u_fifo_ideal (
        .clk_i   (CLK),
        .rst_n_i (RSTa),
        .flush_i (flush),
        .push_i  (push_ideal),
        .din_i   (txn_ideal),
        .pop_i   (pop),
        .dout_o  (head_ideal),
        .full_o  (full_ideal),
        .empty_o (empty_ideal)
    );

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        mismatch_d  = mismatch_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        bad_duv_d   = bad_duv_q;
        bad_ideal_d = bad_ideal_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d   = IDLE;
                    tmo_cnt_d = '0;
                end else begin
                    if (ovf_hit) overflow_d = 1'b1;
                    if (pop) begin
                        tmo_cnt_d = '0;
                        if (same) begin
                            match_d = CNT_W'(sat_inc(SAT_W'(match_q), SAT_W'({CNT_W{1'b1}})));
                        end else begin
                            mismatch_d = CNT_W'(sat_inc(SAT_W'(mismatch_q), SAT_W'({CNT_W{1'b1}})));
                            if (!err_q) begin
                                err_d       = 1'b1;
                                bad_duv_d   = WIDTH'(head_duv.addr);
                                bad_ideal_d = WIDTH'(head_ideal.addr);
                            end
                            if (STOP_ON_ERR != 0) state_d = HALT;
                        end
                    end else if (lopsided) begin
                        if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                            tmo_cnt_d = TW'(TIMEOUT);
                            timeout_d = 1'b1;
                            state_d   = HALT;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TW'(1);
                        end
                    end else begin
                        tmo_cnt_d = '0;
                    end
                end
            end
            HALT: begin
                if (!enable) begin
                    state_d   = IDLE;
                    tmo_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            state_q     <= IDLE;
            match_q     <= '0;
            mismatch_q  <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            bad_duv_q   <= '0;
            bad_ideal_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            bad_duv_q   <= bad_duv_d;
            bad_ideal_q <= bad_ideal_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign match_count    = match_q;
    assign mismatch_count = mismatch_q;
    assign err            = err_q;
    assign timeout        = timeout_q;
    assign overflow       = overflow_q;
    assign halted         = (state_q == HALT);
    assign bad_addr_duv   = bad_duv_q;
    assign bad_addr_ideal = bad_ideal_q;

endmodule

// File: tb/tb_bus_lockstep_checker.sv
// Directed bench: a halting checker and a non-halting, 3-bit-counter checker share one stimulus.
module tb_bus_lockstep_checker;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RSTa = 1'b0;
    logic enable = 1'b0;
    logic MemRead = 1'b0, MemWrite = 1'b0, MemRead_ideal = 1'b0, MemWrite_ideal = 1'b0;
    logic [W-1:0] address = '0, write_data = '0, address_ideal = '0, write_data_ideal = '0;

    logic [15:0]  match_count, mismatch_count;
    logic         err, timeout, overflow, halted;
    logic [W-1:0] bad_addr_duv, bad_addr_ideal;

    logic [2:0]   c_match, c_mismatch;
    logic         c_err, c_timeout, c_overflow, c_halted;
    logic [W-1:0] c_bad_duv, c_bad_ideal;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    bus_lockstep_checker #(.WIDTH(W), .DEPTH(8), .TIMEOUT(64), .STOP_ON_ERR(1), .CNT_W(16)) dut (
        .CLK(CLK), .RSTa(RSTa), .enable(enable),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address), .write_data(write_data),
        .MemRead_ideal(MemRead_ideal), .MemWrite_ideal(MemWrite_ideal),
        .address_ideal(address_ideal), .write_data_ideal(write_data_ideal),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .err(err), .timeout(timeout), .overflow(overflow), .halted(halted),
        .bad_addr_duv(bad_addr_duv), .bad_addr_ideal(bad_addr_ideal)
    );

    bus_lockstep_checker #(.WIDTH(W), .DEPTH(8), .TIMEOUT(64), .STOP_ON_ERR(0), .CNT_W(3)) dut_c (
        .CLK(CLK), .RSTa(RSTa), .enable(enable),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address), .write_data(write_data),
        .MemRead_ideal(MemRead_ideal), .MemWrite_ideal(MemWrite_ideal),
        .address_ideal(address_ideal), .write_data_ideal(write_data_ideal),
        .match_count(c_match), .mismatch_count(c_mismatch),
        .err(c_err), .timeout(c_timeout), .overflow(c_overflow), .halted(c_halted),
        .bad_addr_duv(c_bad_duv), .bad_addr_ideal(c_bad_ideal)
    );

    typedef struct {
        logic         mr, mw;
        logic [W-1:0] a, wd;
        logic         mri, mwi;
        logic [W-1:0] ai, wdi;
        int           exp_match;
        int           exp_match_c;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [W-1:0] a, input logic [W-1:0] wd,
                         input logic mri, input logic mwi, input logic [W-1:0] ai, input logic [W-1:0] wdi);
        MemRead = mr; MemWrite = mw; address = a; write_data = wd;
        MemRead_ideal = mri; MemWrite_ideal = mwi; address_ideal = ai; write_data_ideal = wdi;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        RSTa = 1'b0;
        enable = 1'b0;
        idle_bus();
        step();
        RSTa = 1'b1;
    endtask

    task automatic start_run();
        enable = 1'b1;
        idle_bus();
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_match"}, match_count, 0);
        chk({tag, "_mismatch"}, mismatch_count, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_bad_duv"}, bad_addr_duv, 0);
        chk({tag, "_bad_ideal"}, bad_addr_ideal, 0);
    endtask

    initial begin
        // identical streams, then a read pair with differing write_data and a both-strobes write
        for (int i = 0; i < 14; i++) begin
            tbl[i].mr = 1'b0; tbl[i].mw = 1'b0; tbl[i].a = '0; tbl[i].wd = '0;
            tbl[i].mri = 1'b0; tbl[i].mwi = 1'b0; tbl[i].ai = '0; tbl[i].wdi = '0;
            tbl[i].exp_match = (i <= 10) ? i : i - 1;
            tbl[i].exp_match_c = 7;
            if (i < 8) tbl[i].exp_match_c = i;
            if (i < 10) begin
                tbl[i].mw = 1'b1; tbl[i].mwi = 1'b1;
                tbl[i].a = 32'h100 + 32'(4 * i); tbl[i].ai = 32'h100 + 32'(4 * i);
                tbl[i].wd = 32'hA000_0000 + 32'(i); tbl[i].wdi = 32'hA000_0000 + 32'(i);
            end
        end
        tbl[11].mr = 1'b1; tbl[11].a = 32'h300; tbl[11].wd = 32'h1111;
        tbl[11].mri = 1'b1; tbl[11].ai = 32'h300; tbl[11].wdi = 32'h2222;
        tbl[12].mr = 1'b1; tbl[12].mw = 1'b1; tbl[12].a = 32'h304; tbl[12].wd = 32'h5;
        tbl[12].mwi = 1'b1; tbl[12].ai = 32'h304; tbl[12].wdi = 32'h5;

        RSTa = 1'b0;
        step();
        step();
        RSTa = 1'b1;
        chk_all_zero("reset");

        start_run();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].mr, tbl[i].mw, tbl[i].a, tbl[i].wd, tbl[i].mri, tbl[i].mwi, tbl[i].ai, tbl[i].wdi);
            step();
            chk($sformatf("ident_match_%0d", i), match_count, tbl[i].exp_match);
            chk($sformatf("ident_sat_match_%0d", i), c_match, tbl[i].exp_match_c);
            chk($sformatf("ident_mismatch_%0d", i), mismatch_count, 0);
        end
        chk("ident_err", err, 0);
        chk("ident_halted", halted, 0);

        // DUV issues the same reads three cycles behind the ideal core
        do_reset();
        start_run();
        for (int c = 0; c < 11; c++) begin
            drive((c >= 3 && c < 8), 1'b0, 32'h400 + 32'(4 * (c - 3)), 32'hFFFF_0000 + 32'(c),
                  (c < 5), 1'b0, 32'h400 + 32'(4 * c), 32'h0);
            step();
            if (c == 3) chk("skew_early", match_count, 0);
            if (c == 4) chk("skew_first", match_count, 1);
        end
        chk("skew_match", match_count, 5);
        chk("skew_mismatch", mismatch_count, 0);
        chk("skew_timeout", timeout, 0);
        chk("skew_overflow", overflow, 0);

        // single data mismatch with halting
        do_reset();
        start_run();
        drive(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b1, 32'h200, 32'hDEADBEEE);
        step();
        chk("mm_latency_err", err, 0);
        chk("mm_latency_cnt", mismatch_count, 0);
        idle_bus();
        step();
        chk("mm_err", err, 1);
        chk("mm_cnt", mismatch_count, 1);
        chk("mm_halted", halted, 1);
        chk("mm_bad_duv", bad_addr_duv, 32'h200);
        chk("mm_bad_ideal", bad_addr_ideal, 32'h200);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h204 + 32'(4 * i), 32'(i), 1'b0, 1'b1, 32'h204 + 32'(4 * i), 32'(i));
            step();
        end
        idle_bus();
        step();
        chk("mm_frozen_match", match_count, 0);
        chk("mm_frozen_mismatch", mismatch_count, 1);
        chk("mm_still_halted", halted, 1);
        chk("mm_nostop_halted", c_halted, 0);
        chk("mm_nostop_match", c_match, 3);

        // 3 mismatches among 8 pairs: address, data, and read-vs-write
        do_reset();
        start_run();
        for (int p = 0; p < 8; p++) begin
            drive((p == 7), (p != 7), 32'h500 + 32'(4 * p), 32'(p),
                  1'b0, 1'b1, (p == 2) ? 32'h5F8 : 32'h500 + 32'(4 * p), (p == 4) ? 32'(p ^ 32'hFF) : 32'(p));
            step();
        end
        idle_bus();
        step();
        chk("multi_mismatch", c_mismatch, 3);
        chk("multi_match", c_match, 5);
        chk("multi_err", c_err, 1);
        chk("multi_halted", c_halted, 0);
        chk("multi_bad_duv", c_bad_duv, 32'h508);
        chk("multi_bad_ideal", c_bad_ideal, 32'h5F8);
        chk("multi_stop_match", match_count, 2);
        chk("multi_stop_mismatch", mismatch_count, 1);
        chk("multi_stop_bad_ideal", bad_addr_ideal, 32'h5F8);

        // ideal floods its FIFO while the DUV is silent
        do_reset();
        start_run();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h900 + 32'(4 * i), 32'(i));
            step();
            if (i == 7) chk("ovf_at_full", overflow, 0);
            if (i == 8) chk("ovf_dropped", overflow, 1);
        end
        idle_bus();
        for (int n = 0; n < 55; n++) step();
        chk("tmo_before", timeout, 0);
        chk("tmo_before_halted", halted, 0);
        step();
        chk("tmo_fire", timeout, 1);
        chk("tmo_halted", halted, 1);
        chk("tmo_fire_c", c_timeout, 1);
        enable = 1'b0;
        step();
        chk("tmo_exit_halted", halted, 0);
        chk("tmo_sticky", timeout, 1);
        chk("ovf_sticky", overflow, 1);
        start_run();
        drive(1'b0, 1'b1, 32'hA00, 32'h1, 1'b0, 1'b1, 32'hA00, 32'h1);
        step();
        idle_bus();
        step();
        chk("flush_match", match_count, 1);
        chk("flush_mismatch", mismatch_count, 0);

        // reset with entries queued
        do_reset();
        start_run();
        drive(1'b0, 1'b1, 32'h700, 32'h7, 1'b0, 1'b1, 32'h700, 32'h7);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h710 + 32'(4 * i), 32'(i));
            step();
        end
        idle_bus();
        chk("midrst_pre_match", match_count, 1);
        RSTa = 1'b0;
        step();
        RSTa = 1'b1;
        chk_all_zero("midrst");
        drive(1'b0, 1'b1, 32'h7F0, 32'h9, 1'b0, 1'b0, '0, '0);
        step();
        chk("midrst_enter_halted", halted, 0);
        drive(1'b0, 1'b1, 32'h720, 32'h3, 1'b0, 1'b1, 32'h720, 32'h3);
        step();
        idle_bus();
        step();
        chk("midrst_after_match", match_count, 1);
        chk("midrst_after_mismatch", mismatch_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
